peregrine_inbound_pif_bridge: RTL and testbench
===============================================

Name: peregrine_inbound_pif_bridge

Overview:
Parametrised, registered successor to the straight-wire inbound PIF loopback. Sits between the external inbound PIF master and the Peregrine core inbound PIF slave port. Buffers request beats in a request FIFO and response beats in a response FIFO, with configurable data/ID width, and limits outstanding transactions. Breaks every combinational path between the two sides and reports idle/error status for the cosim harness.

Parameters:
DATA_W, 32, PIF data width; legal values 32, 64, 128. Byte-enable width BE_W = DATA_W/8 is derived.
ID_W, 6, request/response ID width.
REQ_DEPTH, 4, request FIFO entries; power of 2, minimum 2.
RSP_DEPTH, 4, response FIFO entries; power of 2, minimum 2.
MAX_OUTSTANDING, 8, maximum transactions accepted but not yet responded to; range 1..255.

Ports:
CLK  in  1  clock; all state on rising edge
Reset  in  1  asynchronous active-high reset
PIReqValid_M  in  1  master request beat valid
POReqRdy_M  out  1  bridge can accept a request beat
PIReqCntl_M  in  8  request control; bit0 = last beat of transaction
PIReqAdrs_M  in  32  request address
PIReqData_M  in  DATA_W  request write data
PIReqDataBE_M  in  BE_W  request byte enables
PIReqId_M  in  ID_W  request ID
PIReqPriority_M  in  2  request priority
PORespValid_M  out  1  response beat valid to master
PIRespRdy_M  in  1  master accepts response beat
PORespCntl_M  out  8  response control; bit0 = last beat
PORespData_M  out  DATA_W  response data
PORespId_M  out  ID_W  response ID
PORespPriority_M  out  2  response priority
PIReqValid_S, PIReqCntl_S, PIReqAdrs_S, PIReqData_S, PIReqDataBE_S, PIReqId_S, PIReqPriority_S  out  as _M counterparts  request beat to core
POReqRdy_S  in  1  core accepts request beat
PORespValid_S, PORespCntl_S, PORespData_S, PORespId_S, PORespPriority_S  in  as _M counterparts  response beat from core
PIRespRdy_S  out  1  bridge can accept a response beat
Idle  out  1  no outstanding transactions and both FIFOs empty
ErrUnderflow  out  1  sticky: last-beat response seen while outstanding count was 0

Behaviour:
- Reset (async assert, sync release): FIFOs empty; outstanding count = 0; ErrUnderflow = 0. Outputs: PIReqValid_S = 0, PORespValid_M = 0, POReqRdy_M = 0 while Reset is high, PIRespRdy_S = 1 after release, Idle = 1, all payload outputs = 0.
- Reset mid-transfer drops all buffered beats. No partial transaction survives.
- Request path:
  - Push on PIReqValid_M & POReqRdy_M. The full 8+32+DATA_W+BE_W+ID_W+2 payload is stored.
  - POReqRdy_M = !req_full & (cnt < MAX_OUTSTANDING). Combinational from registered state only, never from PIReqValid_M.
  - PIReqValid_S = !req_empty. Payload is driven from the head entry, so minimum latency is 1 cycle (accept in cycle N, valid in N+1). There is no bypass.
  - Pop on PIReqValid_S & POReqRdy_S.
  - Push and pop in the same cycle are allowed when not full; level is unchanged.
  - When full, push is blocked even if a pop occurs that cycle (no full pass-through).
  - Head payload is held stable while PIReqValid_S is high and not popped.
- Response path: same FIFO rules. Push on PORespValid_S & PIRespRdy_S, with PIRespRdy_S = !rsp_full. Pop on PORespValid_M & PIRespRdy_M. Latency is 1 cycle.
- Outstanding count (8-bit cnt):
  - Increments on an accepted master request beat with PIReqCntl_M[0] = 1.
  - Decrements on an accepted master response beat with PORespCntl_M[0] = 1.
  - Both in the same cycle: unchanged.
  - Decrement at cnt = 0: cnt stays 0 and ErrUnderflow sets, remaining set until Reset.
  - cnt never exceeds MAX_OUTSTANDING. At cnt = MAX, POReqRdy_M stays low, including for mid-transaction beats, until a response decrements cnt.
- Idle = (cnt == 0) & req_empty & rsp_empty, registered-state derived.
- FIFO pointers are log2(DEPTH)+1 bits. Full and empty are decided by the MSB compare; pointers wrap modulo 2*DEPTH.
- Ordering is strictly FIFO on both paths. No reordering by ID or priority.

Test Plan:
- Single read: master issues Cntl=0x01, Adrs=0x1000_0000, Id=5 → PIReqValid_S rises exactly 1 cycle after accept with identical fields. Core responds Data=0xDEADBEEF, Cntl=0x01 → PORespValid_M 1 cycle later with Data=0xDEADBEEF, Id=5. Idle returns to 1.
- Backpressure fill: POReqRdy_S=0, 6 beats offered with REQ_DEPTH=4 → exactly 4 accepted, POReqRdy_M=0. Release → beats emerge in order with no loss or duplicate.
- Outstanding limit, MAX_OUTSTANDING=2: 3 single-beat reads, core returns no responses → third stalls with cnt=2. One response accepted by master → POReqRdy_M=1 the next cycle and the third read is accepted.
- Simultaneous: request last-beat accept and response last-beat pop in the same cycle at cnt=1 → cnt stays 1. Burst of 4 beats with Cntl[0] only on the 4th → cnt increments once.
- Underflow: inject a response last beat with cnt=0 → ErrUnderflow=1, cnt=0, flag persists. Reset → ErrUnderflow=0.
- Async reset mid-burst (2 of 4 beats buffered) with DATA_W=128 → PIReqValid_S=0 and Idle=1 immediately. After release, a new transaction passes intact with a 16-bit BE.

Source files
------------

// File: rtl/peregrine_inbound_pif_bridge_if.sv
// Inbound PIF bus bundle: a request channel (master -> slave) and a response
// channel (slave -> master), parameterised on data and ID width.
interface peregrine_inbound_pif_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 6
);
  localparam int BE_W = DATA_W / 8;

  logic              PIReqValid;
  logic              POReqRdy;
  logic [7:0]        PIReqCntl;
  logic [31:0]       PIReqAdrs;
  logic [DATA_W-1:0] PIReqData;
  logic [BE_W-1:0]   PIReqDataBE;
  logic [ID_W-1:0]   PIReqId;
  logic [1:0]        PIReqPriority;

  logic              PORespValid;
  logic              PIRespRdy;
  logic [7:0]        PORespCntl;
  logic [DATA_W-1:0] PORespData;
  logic [ID_W-1:0]   PORespId;
  logic [1:0]        PORespPriority;

  modport master (
    output PIReqValid, PIReqCntl, PIReqAdrs, PIReqData, PIReqDataBE, PIReqId, PIReqPriority,
    input  POReqRdy,
    input  PORespValid, PORespCntl, PORespData, PORespId, PORespPriority,
    output PIRespRdy
  );

  modport slave (
    input  PIReqValid, PIReqCntl, PIReqAdrs, PIReqData, PIReqDataBE, PIReqId, PIReqPriority,
    output POReqRdy,
    output PORespValid, PORespCntl, PORespData, PORespId, PORespPriority,
    input  PIRespRdy
  );
endinterface

// File: rtl/peregrine_inbound_pif_bridge.sv
// Registered inbound PIF bridge: request and response FIFOs between the external
// master and the core slave port, with an outstanding-transaction limiter.

module peregrine_pif_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

module peregrine_inbound_pif_bridge #(
  parameter int DATA_W          = 32,
  parameter int ID_W            = 6,
  parameter int REQ_DEPTH       = 4,
  parameter int RSP_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                          CLK,
  input  logic                          Reset,
  peregrine_inbound_pif_bridge_if.slave  pif_m,
  peregrine_inbound_pif_bridge_if.master pif_s,
  output logic                          Idle,
  output logic                          ErrUnderflow
);
  localparam int BE_W  = DATA_W / 8;
  localparam int REQ_W = 8 + 32 + DATA_W + BE_W + ID_W + 2;
  localparam int RSP_W = 8 + DATA_W + ID_W + 2;
  localparam logic [7:0] CNT_MAX = 8'(MAX_OUTSTANDING);

  logic             req_push, req_pop, req_full, req_empty;
  logic             rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [REQ_W-1:0] req_wdata, req_rdata;
  logic [RSP_W-1:0] rsp_wdata, rsp_rdata;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             cnt_inc, cnt_dec;

  // Request path: ready depends on registered state only, never on PIReqValid.
  assign pif_m.POReqRdy = !Reset && !req_full && (cnt_q < CNT_MAX);
  assign req_push       = pif_m.PIReqValid && pif_m.POReqRdy;
  assign req_pop        = pif_s.PIReqValid && pif_s.POReqRdy;
  assign req_wdata      = {pif_m.PIReqCntl, pif_m.PIReqAdrs, pif_m.PIReqData,
                           pif_m.PIReqDataBE, pif_m.PIReqId, pif_m.PIReqPriority};

  peregrine_pif_fifo #(.W(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .push_i  (req_push),
    .pop_i   (req_pop),
    .wdata_i (req_wdata),
    .rdata_o (req_rdata),
    .full_o  (req_full),
    .empty_o (req_empty)
  );

  assign pif_s.PIReqValid = !req_empty;
  assign {pif_s.PIReqCntl, pif_s.PIReqAdrs, pif_s.PIReqData,
          pif_s.PIReqDataBE, pif_s.PIReqId, pif_s.PIReqPriority} = req_rdata;

  assign pif_s.PIRespRdy = !rsp_full;
  assign rsp_push        = pif_s.PORespValid && pif_s.PIRespRdy;
  assign rsp_pop         = pif_m.PORespValid && pif_m.PIRespRdy;
  assign rsp_wdata       = {pif_s.PORespCntl, pif_s.PORespData,
                            pif_s.PORespId, pif_s.PORespPriority};

  peregrine_pif_fifo #(.W(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .push_i  (rsp_push),
    .pop_i   (rsp_pop),
    .wdata_i (rsp_wdata),
    .rdata_o (rsp_rdata),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );

  assign pif_m.PORespValid = !rsp_empty;
  assign {pif_m.PORespCntl, pif_m.PORespData,
          pif_m.PORespId, pif_m.PORespPriority} = rsp_rdata;

  // A transaction opens on its last request beat and closes on its last response beat.
  assign cnt_inc = req_push && pif_m.PIReqCntl[0];
  assign cnt_dec = rsp_pop && pif_m.PORespCntl[0];

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (cnt_inc && !cnt_dec) begin
      cnt_d = cnt_q + 8'd1;
    end else if (cnt_dec && !cnt_inc) begin
      if (cnt_q == 8'd0) err_d = 1'b1;
      else               cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign Idle         = (cnt_q == 8'd0) && req_empty && rsp_empty;
  assign ErrUnderflow = err_q;
endmodule

// File: tb/tb_peregrine_inbound_pif_bridge.sv
// Bench for the inbound PIF bridge: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_peregrine_inbound_pif_bridge;
  localparam int DW  = 128;
  localparam int BW  = DW / 8;
  localparam int IW  = 6;
  localparam int RD  = 4;
  localparam int SD  = 4;
  localparam int MAX = 2;

  typedef struct packed {
    logic [7:0]    cntl;
    logic [31:0]   adrs;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [IW-1:0] id;
    logic [1:0]    pri;
  } req_t;

  typedef struct packed {
    logic [7:0]    cntl;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    pri;
  } rsp_t;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  logic Idle, ErrUnderflow;

  peregrine_inbound_pif_bridge_if #(.DATA_W(DW), .ID_W(IW)) pif_m ();
  peregrine_inbound_pif_bridge_if #(.DATA_W(DW), .ID_W(IW)) pif_s ();

  peregrine_inbound_pif_bridge #(
    .DATA_W(DW), .ID_W(IW), .REQ_DEPTH(RD), .RSP_DEPTH(SD), .MAX_OUTSTANDING(MAX)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .pif_m        (pif_m),
    .pif_s        (pif_s),
    .Idle         (Idle),
    .ErrUnderflow (ErrUnderflow)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: two ordered queues, a transaction count and a sticky flag.
  req_t req_q[$];
  rsp_t rsp_q[$];
  int   cnt     = 0;
  bit   err     = 1'b0;
  int   req_acc = 0;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit m_req_rdy();
    return !Reset && (req_q.size() < RD) && (cnt < MAX);
  endfunction

  always @(posedge CLK or posedge Reset) begin
    bit rq_push, rq_pop, rs_push, rs_pop, inc, dec;
    req_t nr;
    rsp_t ns;
    if (Reset) begin
      req_q.delete();
      rsp_q.delete();
      cnt = 0;
      err = 1'b0;
    end else begin
      rq_push = pif_m.PIReqValid && m_req_rdy();
      rq_pop  = (req_q.size() != 0) && pif_s.POReqRdy;
      rs_push = pif_s.PORespValid && (rsp_q.size() < SD);
      rs_pop  = (rsp_q.size() != 0) && pif_m.PIRespRdy;
      inc = rq_push && pif_m.PIReqCntl[0];
      dec = rs_pop && rsp_q[0].cntl[0];
      nr = {pif_m.PIReqCntl, pif_m.PIReqAdrs, pif_m.PIReqData,
            pif_m.PIReqDataBE, pif_m.PIReqId, pif_m.PIReqPriority};
      ns = {pif_s.PORespCntl, pif_s.PORespData, pif_s.PORespId, pif_s.PORespPriority};
      if (rq_pop) void'(req_q.pop_front());
      if (rq_push) begin
        req_q.push_back(nr);
        req_acc++;
      end
      if (rs_pop) void'(rsp_q.pop_front());
      if (rs_push) rsp_q.push_back(ns);
      if (inc && !dec) cnt++;
      else if (dec && !inc) begin
        if (cnt == 0) err = 1'b1;
        else          cnt--;
      end
    end
  end

  always @(negedge CLK) begin
    req_t dreq;
    rsp_t drsp;
    if (!Reset) begin
      dreq = {pif_s.PIReqCntl, pif_s.PIReqAdrs, pif_s.PIReqData,
              pif_s.PIReqDataBE, pif_s.PIReqId, pif_s.PIReqPriority};
      drsp = {pif_m.PORespCntl, pif_m.PORespData, pif_m.PORespId, pif_m.PORespPriority};
      chk("req_rdy_m", 256'(pif_m.POReqRdy), 256'(m_req_rdy()));
      chk("req_vld_s", 256'(pif_s.PIReqValid), 256'(req_q.size() != 0));
      chk("rsp_rdy_s", 256'(pif_s.PIRespRdy), 256'(rsp_q.size() < SD));
      chk("rsp_vld_m", 256'(pif_m.PORespValid), 256'(rsp_q.size() != 0));
      chk("idle", 256'(Idle), 256'(cnt == 0 && req_q.size() == 0 && rsp_q.size() == 0));
      chk("err_underflow", 256'(ErrUnderflow), 256'(err));
      if (req_q.size() != 0) chk("req_payload", 256'(dreq), 256'(req_q[0]));
      if (rsp_q.size() != 0) chk("rsp_payload", 256'(drsp), 256'(rsp_q[0]));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic req_beat(input logic [7:0] c);
    pif_m.PIReqValid  = 1'b1;
    pif_m.PIReqCntl   = c;
    pif_m.PIReqAdrs   = $urandom;
    pif_m.PIReqData   = {$urandom, $urandom, $urandom, $urandom};
    pif_m.PIReqDataBE = BW'($urandom);
    pif_m.PIReqId     = IW'($urandom);
    @(negedge CLK);
    pif_m.PIReqValid  = 1'b0;
  endtask

  task automatic rsp_beat(input logic [7:0] c);
    pif_s.PORespValid    = 1'b1;
    pif_s.PORespCntl     = c;
    pif_s.PORespData     = {$urandom, $urandom, $urandom, $urandom};
    pif_s.PORespId       = IW'($urandom);
    pif_s.PORespPriority = 2'($urandom);
    @(negedge CLK);
    pif_s.PORespValid    = 1'b0;
  endtask

  initial begin
    int base;
    int got[$];
    pif_m.PIReqValid = 1'b0; pif_m.PIReqCntl = '0; pif_m.PIReqAdrs = '0;
    pif_m.PIReqData = '0; pif_m.PIReqDataBE = '0; pif_m.PIReqId = '0;
    pif_m.PIReqPriority = '0; pif_m.PIRespRdy = 1'b1;
    pif_s.POReqRdy = 1'b1; pif_s.PORespValid = 1'b0; pif_s.PORespCntl = '0;
    pif_s.PORespData = '0; pif_s.PORespId = '0; pif_s.PORespPriority = '0;

    repeat (3) @(negedge CLK);
    chk("rst_req_vld_s", 256'(pif_s.PIReqValid), 256'(0));
    chk("rst_rsp_vld_m", 256'(pif_m.PORespValid), 256'(0));
    chk("rst_req_rdy_m", 256'(pif_m.POReqRdy), 256'(0));
    chk("rst_idle", 256'(Idle), 256'(1));
    chk("rst_err", 256'(ErrUnderflow), 256'(0));
    chk("rst_req_adrs", 256'(pif_s.PIReqAdrs), 256'(0));
    chk("rst_rsp_data", 256'(pif_m.PORespData), 256'(0));
    Reset = 1'b0;
    @(negedge CLK);
    chk("rel_req_rdy_m", 256'(pif_m.POReqRdy), 256'(1));
    chk("rel_rsp_rdy_s", 256'(pif_s.PIRespRdy), 256'(1));

    // Single read, one-cycle latency each way.
    pif_s.POReqRdy = 1'b0; pif_m.PIRespRdy = 1'b0;
    pif_m.PIReqValid = 1'b1; pif_m.PIReqCntl = 8'h01; pif_m.PIReqAdrs = 32'h1000_0000;
    pif_m.PIReqId = 6'd5; pif_m.PIReqDataBE = '1;
    pif_m.PIReqData = {$urandom, $urandom, $urandom, $urandom};
    chk("rd_vld_before", 256'(pif_s.PIReqValid), 256'(0));
    @(negedge CLK);
    pif_m.PIReqValid = 1'b0;
    chk("rd_vld_lat1", 256'(pif_s.PIReqValid), 256'(1));
    chk("rd_adrs", 256'(pif_s.PIReqAdrs), 256'(32'h1000_0000));
    chk("rd_id", 256'(pif_s.PIReqId), 256'(5));
    chk("rd_cntl", 256'(pif_s.PIReqCntl), 256'(1));
    chk("rd_busy", 256'(Idle), 256'(0));
    pif_s.POReqRdy = 1'b1;
    @(negedge CLK);
    chk("rd_popped", 256'(pif_s.PIReqValid), 256'(0));
    pif_s.PORespValid = 1'b1; pif_s.PORespCntl = 8'h01;
    pif_s.PORespData = 128'hDEADBEEF; pif_s.PORespId = 6'd5;
    @(negedge CLK);
    pif_s.PORespValid = 1'b0;
    chk("rsp_vld_lat1", 256'(pif_m.PORespValid), 256'(1));
    chk("rsp_data", 256'(pif_m.PORespData), 256'(128'hDEADBEEF));
    chk("rsp_id", 256'(pif_m.PORespId), 256'(5));
    pif_m.PIRespRdy = 1'b1;
    @(negedge CLK);
    chk("rd_idle_again", 256'(Idle), 256'(1));

    // Backpressure fill: six beats offered, four fit.
    pif_s.POReqRdy = 1'b0;
    base = req_acc;
    for (int i = 0; i < 6; i++) begin
      pif_m.PIReqValid = 1'b1; pif_m.PIReqCntl = 8'h00;
      pif_m.PIReqAdrs = 32'h2000 + 32'(req_acc - base);
      pif_m.PIReqId = IW'(i);
      @(negedge CLK);
    end
    pif_m.PIReqValid = 1'b0;
    chk("fill_accepted", 256'(req_acc - base), 256'(4));
    chk("fill_rdy_low", 256'(pif_m.POReqRdy), 256'(0));
    pif_s.POReqRdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (pif_s.PIReqValid) got.push_back(int'(pif_s.PIReqAdrs));
      @(negedge CLK);
    end
    chk("drain_count", 256'(got.size()), 256'(4));
    for (int i = 0; i < 4; i++)
      chk("drain_order", 256'((i < got.size()) ? got[i] : -1), 256'(32'h2000 + i));

    // Outstanding limit with no responses.
    base = req_acc;
    for (int i = 0; i < 5; i++) begin
      pif_m.PIReqValid = 1'b1; pif_m.PIReqCntl = 8'h01;
      pif_m.PIReqAdrs = 32'h3000 + 32'(req_acc - base);
      @(negedge CLK);
    end
    chk("lim_model_cnt", 256'(cnt), 256'(2));
    chk("lim_accepted", 256'(req_acc - base), 256'(2));
    chk("lim_stall", 256'(pif_m.POReqRdy), 256'(0));
    rsp_beat(8'h01);
    chk("lim_still_stalled", 256'(pif_m.POReqRdy), 256'(0));
    @(negedge CLK);
    chk("lim_rdy_back", 256'(pif_m.POReqRdy), 256'(1));
    @(negedge CLK);
    pif_m.PIReqValid = 1'b0;
    chk("lim_third_acc", 256'(req_acc - base), 256'(3));
    chk("lim_stall_again", 256'(pif_m.POReqRdy), 256'(0));
    rsp_beat(8'h01); rsp_beat(8'h01);
    repeat (2) @(negedge CLK);
    chk("lim_idle", 256'(Idle), 256'(1));

    // Simultaneous open and close, then a four-beat burst.
    req_beat(8'h01);
    pif_m.PIRespRdy = 1'b0;
    rsp_beat(8'h01);
    pif_m.PIReqValid = 1'b1; pif_m.PIReqCntl = 8'h01; pif_m.PIRespRdy = 1'b1;
    @(negedge CLK);
    pif_m.PIReqValid = 1'b0;
    chk("sim_model_cnt", 256'(cnt), 256'(1));
    chk("sim_not_idle", 256'(Idle), 256'(0));
    chk("sim_rdy", 256'(pif_m.POReqRdy), 256'(1));
    for (int i = 0; i < 4; i++) req_beat((i == 3) ? 8'h01 : 8'h00);
    chk("burst_model_cnt", 256'(cnt), 256'(2));
    chk("burst_at_max", 256'(pif_m.POReqRdy), 256'(0));
    rsp_beat(8'h01); rsp_beat(8'h01);
    repeat (2) @(negedge CLK);
    chk("burst_idle", 256'(Idle), 256'(1));

    // Underflow: non-last response is harmless, last response at zero sets the flag.
    rsp_beat(8'h00);
    @(negedge CLK);
    chk("uf_nonlast", 256'(ErrUnderflow), 256'(0));
    rsp_beat(8'h01);
    @(negedge CLK);
    chk("uf_set", 256'(ErrUnderflow), 256'(1));
    chk("uf_idle", 256'(Idle), 256'(1));
    repeat (3) @(negedge CLK);
    chk("uf_sticky", 256'(ErrUnderflow), 256'(1));
    Reset = 1'b1;
    @(negedge CLK);
    chk("uf_rst_clear", 256'(ErrUnderflow), 256'(0));
    Reset = 1'b0;
    @(negedge CLK);

    // Async reset with half a burst buffered.
    pif_s.POReqRdy = 1'b0;
    req_beat(8'h00); req_beat(8'h00);
    pif_m.PIReqValid = 1'b1; pif_m.PIReqCntl = 8'h00;
    #2 Reset = 1'b1;
    #1;
    chk("ar_req_vld_s", 256'(pif_s.PIReqValid), 256'(0));
    chk("ar_idle", 256'(Idle), 256'(1));
    chk("ar_rdy_m", 256'(pif_m.POReqRdy), 256'(0));
    chk("ar_data_zero", 256'(pif_s.PIReqData), 256'(0));
    @(negedge CLK);
    pif_m.PIReqValid = 1'b0;
    Reset = 1'b0;
    @(negedge CLK);
    pif_m.PIReqValid = 1'b1; pif_m.PIReqCntl = 8'h01; pif_m.PIReqAdrs = 32'h4000_0000;
    pif_m.PIReqData = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    pif_m.PIReqDataBE = 16'hA5C3; pif_m.PIReqId = 6'h2A; pif_m.PIReqPriority = 2'b10;
    @(negedge CLK);
    pif_m.PIReqValid = 1'b0;
    chk("ar_new_be", 256'(pif_s.PIReqDataBE), 256'(16'hA5C3));
    chk("ar_new_data", 256'(pif_s.PIReqData), 256'(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210));
    chk("ar_new_id", 256'(pif_s.PIReqId), 256'(6'h2A));
    chk("ar_new_pri", 256'(pif_s.PIReqPriority), 256'(2'b10));
    pif_s.POReqRdy = 1'b1;
    rsp_beat(8'h01);
    repeat (2) @(negedge CLK);
    chk("ar_new_idle", 256'(Idle), 256'(1));

    // Randomized traffic, with one reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      pif_m.PIReqValid    = ($urandom_range(0, 2) != 0);
      pif_m.PIReqCntl     = 8'($urandom);
      pif_m.PIReqAdrs     = $urandom;
      pif_m.PIReqData     = {$urandom, $urandom, $urandom, $urandom};
      pif_m.PIReqDataBE   = BW'($urandom);
      pif_m.PIReqId       = IW'($urandom);
      pif_m.PIReqPriority = 2'($urandom);
      pif_m.PIRespRdy     = ($urandom_range(0, 3) != 0);
      pif_s.POReqRdy      = ($urandom_range(0, 2) != 0);
      pif_s.PORespValid   = ($urandom_range(0, 2) != 0);
      pif_s.PORespCntl    = 8'($urandom);
      pif_s.PORespData    = {$urandom, $urandom, $urandom, $urandom};
      pif_s.PORespId      = IW'($urandom);
      pif_s.PORespPriority = 2'($urandom);
      Reset = (i == 1000);
      @(negedge CLK);
    end
    Reset = 1'b0;
    pif_m.PIReqValid = 1'b0;
    pif_s.PORespValid = 1'b0;
    repeat (4) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
